// File: rtl/aes_avalon_master.sv
// Avalon-MM master that sequences one AES operation on a memory-mapped slave:
// load key and message, start, poll for done, read the result back, clear start.
module aes_avalon_master #(
  parameter int unsigned POLL_MAX = 1023
) (
  input  logic         CLK,
  input  logic         RESET_N,
  input  logic         START,
  input  logic [127:0] KEY,
  input  logic [127:0] MSG_EN,
  output logic         BUSY,
  output logic         DONE,
  output logic         TIMEOUT,
  output logic [127:0] MSG_DE,
  output logic         AVL_READ,
  output logic         AVL_WRITE,
  output logic         AVL_CS,
  output logic [3:0]   AVL_BYTE_EN,
  output logic [3:0]   AVL_ADDR,
  output logic [31:0]  AVL_WRITEDATA,
  input  logic [31:0]  AVL_READDATA,
  input  logic         AVL_WAITREQUEST
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWrKey = 3'd1;
  localparam logic [2:0] StWrMsg = 3'd2;
  localparam logic [2:0] StWrGo  = 3'd3;
  localparam logic [2:0] StPoll  = 3'd4;
  localparam logic [2:0] StRdDe  = 3'd5;
  localparam logic [2:0] StWrClr = 3'd6;
  localparam logic [2:0] StFin   = 3'd7;

  localparam logic [9:0] PollLast  = 10'(POLL_MAX - 1);
  localparam logic [3:0] AddrStart = 4'd14;
  localparam logic [3:0] AddrDone  = 4'd15;

  logic [2:0]   state_q, state_d;
  logic [1:0]   word_q, word_d;
  logic [9:0]   poll_q, poll_d;
  logic         abort_q, abort_d;
  logic [127:0] key_q, msg_q, msg_de_q;

  logic         rd, wr, active, xfer_done;
  logic [3:0]   addr;
  logic [31:0]  wdata;

  // Word 0 is the most significant 32 bits of the block.
  function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] k);
    logic [31:0] w;
    unique case (k)
      2'd0:    w = v[127:96];
      2'd1:    w = v[95:64];
      2'd2:    w = v[63:32];
      default: w = v[31:0];
    endcase
    return w;
  endfunction

  // Bus outputs decode purely from registered state, so they stay frozen while stalled.
  always_comb begin
    rd    = 1'b0;
    wr    = 1'b0;
    addr  = 4'd0;
    wdata = 32'd0;
    unique case (state_q)
      StWrKey: begin wr = 1'b1; addr = {2'b00, word_q}; wdata = word_of(key_q, word_q); end
      StWrMsg: begin wr = 1'b1; addr = {2'b01, word_q}; wdata = word_of(msg_q, word_q); end
      StWrGo:  begin wr = 1'b1; addr = AddrStart;       wdata = 32'd1;                  end
      StPoll:  begin rd = 1'b1; addr = AddrDone;                                        end
      StRdDe:  begin rd = 1'b1; addr = {2'b10, word_q};                                 end
      StWrClr: begin wr = 1'b1; addr = AddrStart;       wdata = 32'd0;                  end
      default: ;
    endcase
  end

  assign active    = rd | wr;
  assign xfer_done = active & ~AVL_WAITREQUEST;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    poll_d  = poll_q;
    abort_d = abort_q;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d = StWrKey;
          word_d  = 2'd0;
          poll_d  = 10'd0;
          abort_d = 1'b0;
        end
      end
      StWrKey: begin
        if (xfer_done) begin
          word_d = word_q + 2'd1;
          if (word_q == 2'd3) state_d = StWrMsg;
        end
      end
      StWrMsg: begin
        if (xfer_done) begin
          word_d = word_q + 2'd1;
          if (word_q == 2'd3) state_d = StWrGo;
        end
      end
      StWrGo: begin
        if (xfer_done) begin
          state_d = StPoll;
          poll_d  = 10'd0;
        end
      end
      StPoll: begin
        if (xfer_done) begin
          if (AVL_READDATA[0]) begin
            state_d = StRdDe;
            word_d  = 2'd0;
          end else if (poll_q == PollLast) begin
            state_d = StWrClr;
            abort_d = 1'b1;
          end else begin
            poll_d = poll_q + 10'd1;
          end
        end
      end
      StRdDe: begin
        if (xfer_done) begin
          word_d = word_q + 2'd1;
          if (word_q == 2'd3) state_d = StWrClr;
        end
      end
      StWrClr: begin
        if (xfer_done) state_d = StFin;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= StIdle;
      word_q   <= 2'd0;
      poll_q   <= 10'd0;
      abort_q  <= 1'b0;
      key_q    <= 128'd0;
      msg_q    <= 128'd0;
      msg_de_q <= 128'd0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      poll_q  <= poll_d;
      abort_q <= abort_d;
      if (state_q == StIdle && START) begin
        key_q <= KEY;
        msg_q <= MSG_EN;
      end
      if (state_q == StRdDe && xfer_done) begin
        unique case (word_q)
          2'd0:    msg_de_q[127:96] <= AVL_READDATA;
          2'd1:    msg_de_q[95:64]  <= AVL_READDATA;
          2'd2:    msg_de_q[63:32]  <= AVL_READDATA;
          default: msg_de_q[31:0]   <= AVL_READDATA;
        endcase
      end
    end
  end

  assign BUSY          = (state_q != StIdle);
  assign DONE          = (state_q == StFin) & ~abort_q;
  assign TIMEOUT       = (state_q == StFin) & abort_q;
  assign MSG_DE        = msg_de_q;
  assign AVL_READ      = rd;
  assign AVL_WRITE     = wr;
  assign AVL_CS        = active;
  assign AVL_BYTE_EN   = {4{active}};
  assign AVL_ADDR      = addr;
  assign AVL_WRITEDATA = wdata;

endmodule

// File: tb/tb_aes_avalon_master.sv
// Bench for aes_avalon_master: a behavioural Avalon slave logs every completed
// transfer, and each run is compared against an expected transfer list.
module tb_aes_avalon_master;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic         start = 1'b0;
  logic         sel   = 1'b0;
  logic         start_a, start_b;
  logic [127:0] key    = '0;
  logic [127:0] msg_en = '0;
  logic [31:0]  rdata  = '0;
  logic         wreq   = 1'b0;

  logic a_busy, a_done, a_timeout, a_read, a_write, a_cs;
  logic b_busy, b_done, b_timeout, b_read, b_write, b_cs;
  logic [127:0] a_msg_de, b_msg_de, m_msg_de;
  logic [3:0] a_be, a_addr, b_be, b_addr, m_be, m_addr;
  logic [31:0] a_wdata, b_wdata, m_wdata;
  logic m_busy, m_done, m_timeout, m_read, m_write, m_cs;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  aes_avalon_master u_dut_a (
    .CLK(clk), .RESET_N(rst_n), .START(start_a), .KEY(key), .MSG_EN(msg_en),
    .BUSY(a_busy), .DONE(a_done), .TIMEOUT(a_timeout), .MSG_DE(a_msg_de),
    .AVL_READ(a_read), .AVL_WRITE(a_write), .AVL_CS(a_cs), .AVL_BYTE_EN(a_be),
    .AVL_ADDR(a_addr), .AVL_WRITEDATA(a_wdata), .AVL_READDATA(rdata),
    .AVL_WAITREQUEST(wreq)
  );

  aes_avalon_master #(.POLL_MAX(8)) u_dut_b (
    .CLK(clk), .RESET_N(rst_n), .START(start_b), .KEY(key), .MSG_EN(msg_en),
    .BUSY(b_busy), .DONE(b_done), .TIMEOUT(b_timeout), .MSG_DE(b_msg_de),
    .AVL_READ(b_read), .AVL_WRITE(b_write), .AVL_CS(b_cs), .AVL_BYTE_EN(b_be),
    .AVL_ADDR(b_addr), .AVL_WRITEDATA(b_wdata), .AVL_READDATA(rdata),
    .AVL_WAITREQUEST(wreq)
  );

  assign m_busy    = sel ? b_busy    : a_busy;
  assign m_done    = sel ? b_done    : a_done;
  assign m_timeout = sel ? b_timeout : a_timeout;
  assign m_msg_de  = sel ? b_msg_de  : a_msg_de;
  assign m_read    = sel ? b_read    : a_read;
  assign m_write   = sel ? b_write   : a_write;
  assign m_cs      = sel ? b_cs      : a_cs;
  assign m_be      = sel ? b_be      : a_be;
  assign m_addr    = sel ? b_addr    : a_addr;
  assign m_wdata   = sel ? b_wdata   : a_wdata;

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
  } xfer_t;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave configuration (written by tests only)
  int          run_id = 0;
  int          cfg_zero_polls = 0;
  int          cfg_stall_addr = 0;
  int          cfg_stall_n = 0;
  logic [31:0] cfg_rd [4];

  // Slave state (written by the slave process only)
  xfer_t       log_q[$];
  int          seen_id = 0, polls_seen = 0, stall_left = 0;
  int          proto_err = 0, done_cnt = 0, to_cnt = 0;
  logic        prev_wait = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
  logic [3:0]  prev_addr = '0;
  logic [31:0] prev_wdata = '0;

  // Slave answers at the falling edge; the DUT samples at the next rising edge.
  always @(negedge clk) begin
    xfer_t ent;
    if (run_id != seen_id) begin
      seen_id    = run_id;
      polls_seen = 0;
      stall_left = cfg_stall_n;
    end
    if (prev_wait && (m_read !== prev_rd || m_write !== prev_wr || m_addr !== prev_addr ||
                      m_wdata !== prev_wdata)) proto_err++;
    rdata = $urandom;
    if (m_read || m_write) begin
      if (m_read && m_write) proto_err++;
      if (m_cs !== 1'b1 || m_be !== 4'hF) proto_err++;
      if (stall_left > 0 && int'(m_addr) == cfg_stall_addr) begin
        wreq = 1'b1;
        stall_left--;
      end else begin
        wreq = 1'b0;
        if (m_read && m_addr == 4'd15) begin
          rdata[0] = (polls_seen >= cfg_zero_polls);
          polls_seen++;
        end else if (m_read && m_addr >= 4'd8 && m_addr <= 4'd11) begin
          rdata = cfg_rd[m_addr[1:0]];
        end
        ent.wr = m_write; ent.addr = m_addr; ent.data = m_wdata;
        log_q.push_back(ent);
      end
    end else begin
      wreq = 1'b0;
      if (m_cs !== 1'b0 || m_be !== 4'h0 || m_addr !== 4'h0 || m_wdata !== 32'h0) proto_err++;
    end
    prev_wait = wreq; prev_rd = m_read; prev_wr = m_write;
    prev_addr = m_addr; prev_wdata = m_wdata;
    if (m_done) done_cnt++;
    if (m_timeout) to_cnt++;
  end

  // Reference model: the transfer list a run must produce.
  xfer_t        exp_q[$];
  xfer_t        obs_q[$];
  logic         exp_to;
  int           exp_stall;
  logic [127:0] exp_de_a = '0, exp_de_b = '0;

  task automatic model(input logic [127:0] k, input logic [127:0] m, input int zp,
                       input int pmax);
    xfer_t e;
    exp_q.delete();
    for (int j = 0; j < 4; j++) begin
      e.wr = 1'b1; e.addr = 4'(j); e.data = k[127-32*j -: 32]; exp_q.push_back(e);
    end
    for (int j = 0; j < 4; j++) begin
      e.wr = 1'b1; e.addr = 4'(4 + j); e.data = m[127-32*j -: 32]; exp_q.push_back(e);
    end
    e.wr = 1'b1; e.addr = 4'd14; e.data = 32'd1; exp_q.push_back(e);
    exp_to = (zp >= pmax);
    for (int j = 0; j < (exp_to ? pmax : zp + 1); j++) begin
      e.wr = 1'b0; e.addr = 4'd15; e.data = '0; exp_q.push_back(e);
    end
    if (!exp_to) begin
      for (int j = 0; j < 4; j++) begin
        e.wr = 1'b0; e.addr = 4'(8 + j); e.data = '0; exp_q.push_back(e);
      end
    end
    e.wr = 1'b1; e.addr = 4'd14; e.data = 32'd0; exp_q.push_back(e);
    exp_stall = 0;
    foreach (exp_q[i]) if (int'(exp_q[i].addr) == cfg_stall_addr) exp_stall = cfg_stall_n;
  endtask

  function automatic int first_diff();
    int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (obs_q[i].wr !== exp_q[i].wr || obs_q[i].addr !== exp_q[i].addr ||
          (exp_q[i].wr && obs_q[i].data !== exp_q[i].data)) return i;
    end
    if (obs_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic int count_polls();
    int n = 0;
    foreach (obs_q[i]) if (!obs_q[i].wr && obs_q[i].addr == 4'd15) n++;
    return n;
  endfunction

  // Observations of the last run
  int   obs_lat, obs_done, obs_to, obs_perr;
  logic obs_busy_run, obs_busy_after;

  // mode 0: single START pulse; 1: START held through the run; 2: START toggled randomly
  task automatic do_run(input logic use_b, input logic [127:0] k, input logic [127:0] m,
                        input int mode);
    int base, d0, t0, p0, acc;
    sel = use_b; key = k; msg_en = m;
    @(negedge clk); #1;
    run_id++;
    start = 1'b1;
    base = log_q.size(); d0 = done_cnt; t0 = to_cnt; p0 = proto_err;
    @(posedge clk);
    @(negedge clk); #1;
    acc = cyc;
    obs_busy_run = m_busy;
    if (mode == 0) start = 1'b0;
    key = {$urandom, $urandom, $urandom, $urandom};
    msg_en = {$urandom, $urandom, $urandom, $urandom};
    obs_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      if (m_done || m_timeout) begin
        obs_lat = cyc - acc;
        break;
      end
      @(negedge clk); #1;
      if (mode == 2) start = 1'($urandom);
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    obs_busy_after = m_busy;
    obs_q = log_q[base:$];
    obs_done = done_cnt - d0;
    obs_to = to_cnt - t0;
    obs_perr = proto_err - p0;
  endtask

  task automatic set_slave(input int zp, input int st_addr, input int st_n);
    cfg_zero_polls = zp; cfg_stall_addr = st_addr; cfg_stall_n = st_n;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    tests++;
    if ({a_busy, a_done, a_timeout, b_busy, b_done, b_timeout} !== 6'b0) begin
      fails++; $display("FAIL reset_status got %b want 000000",
                        {a_busy, a_done, a_timeout, b_busy, b_done, b_timeout});
    end
    tests++;
    if ({a_read, a_write, a_cs, a_be, a_addr, a_wdata} !== '0) begin
      fails++; $display("FAIL reset_bus addr %h data %h want 0", a_addr, a_wdata);
    end
    tests++;
    if (a_msg_de !== 128'd0 || b_msg_de !== 128'd0) begin
      fails++; $display("FAIL reset_msg_de got %h want 0", a_msg_de);
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (a_busy !== 1'b0 || log_q.size() != 0) begin
      fails++; $display("FAIL reset_quiet busy %b xfers %0d want 0 0", a_busy, log_q.size());
    end
  endtask

  task automatic test_nominal();
    logic [127:0] k = 128'h000102030405060708090a0b0c0d0e0f;
    logic [127:0] m = 128'hffeeddccbbaa99887766554433221100;
    logic [31:0] w0, w3;
    int d;
    cfg_rd[0] = 32'h11111111; cfg_rd[1] = 32'h22222222;
    cfg_rd[2] = 32'h33333333; cfg_rd[3] = 32'h44444444;
    set_slave(0, 99, 0);
    model(k, m, 0, 1023);
    do_run(1'b0, k, m, 0);
    exp_de_a = 128'h11111111222222223333333344444444;
    d = first_diff();
    tests++;
    if (d != -1) begin
      fails++; $display("FAIL nominal_seq first diff at %0d got %0d xfers want %0d", d,
                        obs_q.size(), exp_q.size());
    end
    w0 = (obs_q.size() > 0) ? obs_q[0].data : 32'hx;
    w3 = (obs_q.size() > 3) ? obs_q[3].data : 32'hx;
    tests++;
    if (w0 !== 32'h00010203 || w3 !== 32'h0c0d0e0f) begin
      fails++; $display("FAIL nominal_key_words got %h %h want 00010203 0c0d0e0f", w0, w3);
    end
    // DONE shows in the FIN cycle, the 16th counted from the accept edge
    tests++;
    if (obs_lat != 15) begin
      fails++; $display("FAIL nominal_latency got %0d want 15", obs_lat);
    end
    tests++;
    if (obs_done != 1 || obs_to != 0) begin
      fails++; $display("FAIL nominal_pulses done %0d timeout %0d want 1 0", obs_done, obs_to);
    end
    tests++;
    if (m_msg_de !== exp_de_a) begin
      fails++; $display("FAIL nominal_msg_de got %h want %h", m_msg_de, exp_de_a);
    end
    tests++;
    if (obs_busy_run !== 1'b1 || obs_busy_after !== 1'b0 || obs_perr != 0) begin
      fails++; $display("FAIL nominal_busy_proto busy %b/%b proto_err %0d want 1/0 0",
                        obs_busy_run, obs_busy_after, obs_perr);
    end
  endtask

  task automatic test_waitstate();
    logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] m = {$urandom, $urandom, $urandom, $urandom};
    int d;
    set_slave(0, 5, 3);
    model(k, m, 0, 1023);
    do_run(1'b0, k, m, 0);
    exp_de_a = {cfg_rd[0], cfg_rd[1], cfg_rd[2], cfg_rd[3]};
    d = first_diff();
    tests++;
    if (d != -1) begin
      fails++; $display("FAIL wait_seq first diff at %0d", d);
    end
    tests++;
    if (obs_lat != 18) begin
      fails++; $display("FAIL wait_latency got %0d want 18", obs_lat);
    end
    tests++;
    if (obs_perr != 0) begin
      fails++; $display("FAIL wait_stable proto_err %0d want 0", obs_perr);
    end
  endtask

  task automatic test_slow_done();
    logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] m = {$urandom, $urandom, $urandom, $urandom};
    int d;
    for (int j = 0; j < 4; j++) cfg_rd[j] = $urandom;
    set_slave(20, 99, 0);
    model(k, m, 20, 1023);
    do_run(1'b0, k, m, 0);
    exp_de_a = {cfg_rd[0], cfg_rd[1], cfg_rd[2], cfg_rd[3]};
    tests++;
    if (count_polls() != 21) begin
      fails++; $display("FAIL slow_polls got %0d want 21", count_polls());
    end
    d = first_diff();
    tests++;
    if (d != -1 || obs_done != 1 || m_msg_de !== exp_de_a) begin
      fails++; $display("FAIL slow_result diff %0d done %0d msg_de %h want -1 1 %h", d,
                        obs_done, m_msg_de, exp_de_a);
    end
  endtask

  task automatic test_timeout();
    logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] m = {$urandom, $urandom, $urandom, $urandom};
    int d;
    for (int j = 0; j < 4; j++) cfg_rd[j] = $urandom;
    set_slave(2, 99, 0);
    model(k, m, 2, 8);
    do_run(1'b1, k, m, 0);
    exp_de_b = {cfg_rd[0], cfg_rd[1], cfg_rd[2], cfg_rd[3]};
    tests++;
    if (m_msg_de !== exp_de_b || obs_done != 1) begin
      fails++; $display("FAIL timeout_prep msg_de %h done %0d want %h 1", m_msg_de, obs_done,
                        exp_de_b);
    end
    for (int j = 0; j < 4; j++) cfg_rd[j] = $urandom;
    set_slave(1000000, 99, 0);
    model(k, m, 1000000, 8);
    do_run(1'b1, k, m, 0);
    d = first_diff();
    tests++;
    if (d != -1 || count_polls() != 8) begin
      fails++; $display("FAIL timeout_seq diff %0d polls %0d want -1 8", d, count_polls());
    end
    tests++;
    if (obs_to != 1 || obs_done != 0 || obs_lat != 18) begin
      fails++; $display("FAIL timeout_pulse timeout %0d done %0d lat %0d want 1 0 18", obs_to,
                        obs_done, obs_lat);
    end
    tests++;
    if (m_msg_de !== exp_de_b) begin
      fails++; $display("FAIL timeout_msg_de got %h want %h", m_msg_de, exp_de_b);
    end
  endtask

  task automatic test_reset_mid_poll();
    logic [127:0] k = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] m = {$urandom, $urandom, $urandom, $urandom};
    int base, snap, d;
    logic reached = 1'b0;
    sel = 1'b0; key = k; msg_en = m;
    set_slave(1000000, 99, 0);
    @(negedge clk); #1;
    run_id++;
    base = log_q.size();
    start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (log_q.size() - base >= 12) begin
        reached = 1'b1;
        break;
      end
    end
    tests++;
    if (!reached || m_read !== 1'b1 || m_addr !== 4'd15) begin
      fails++; $display("FAIL midpoll_reach reached %b read %b addr %h want 1 1 f", reached,
                        m_read, m_addr);
    end
    rst_n = 1'b0;
    #1;
    exp_de_a = '0; exp_de_b = '0;
    tests++;
    if ({a_busy, a_done, a_timeout, a_read, a_write, a_cs, a_be, a_addr, a_wdata} !== '0 ||
        a_msg_de !== 128'd0) begin
      fails++; $display("FAIL midpoll_reset busy %b read %b addr %h msg_de %h want all 0",
                        a_busy, a_read, a_addr, a_msg_de);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    snap = log_q.size();
    repeat (5) @(negedge clk);
    #1;
    tests++;
    if (a_busy !== 1'b0 || log_q.size() != snap) begin
      fails++; $display("FAIL midpoll_no_resume busy %b new xfers %0d want 0 0", a_busy,
                        log_q.size() - snap);
    end
    for (int j = 0; j < 4; j++) cfg_rd[j] = $urandom;
    set_slave(0, 99, 0);
    model(k, m, 0, 1023);
    do_run(1'b0, k, m, 0);
    exp_de_a = {cfg_rd[0], cfg_rd[1], cfg_rd[2], cfg_rd[3]};
    d = first_diff();
    tests++;
    if (d != -1 || obs_done != 1 || m_msg_de !== exp_de_a) begin
      fails++; $display("FAIL midpoll_rerun diff %0d done %0d want -1 1", d, obs_done);
    end
  endtask

  task automatic test_start_while_busy();
    logic [127:0] k, m;
    int d;
    for (int mode = 1; mode <= 2; mode++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      m = {$urandom, $urandom, $urandom, $urandom};
      for (int j = 0; j < 4; j++) cfg_rd[j] = $urandom;
      set_slave(3, 99, 0);
      model(k, m, 3, 1023);
      do_run(1'b0, k, m, mode);
      exp_de_a = {cfg_rd[0], cfg_rd[1], cfg_rd[2], cfg_rd[3]};
      d = first_diff();
      tests++;
      if (d != -1 || obs_done != 1 || obs_busy_after !== 1'b0 || obs_lat != exp_q.size()) begin
        fails++; $display("FAIL start_busy mode %0d diff %0d done %0d busy %b lat %0d want -1 1 0 %0d",
                          mode, d, obs_done, obs_busy_after, obs_lat, exp_q.size());
      end
    end
  endtask

  task automatic test_random();
    logic [127:0] k, m, want_de;
    logic use_b;
    int zp, d;
    for (int it = 0; it < 12; it++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      m = {$urandom, $urandom, $urandom, $urandom};
      for (int j = 0; j < 4; j++) cfg_rd[j] = $urandom;
      use_b = 1'($urandom);
      zp = $urandom_range(0, 12);
      set_slave(zp, $urandom_range(0, 15), $urandom_range(0, 3));
      model(k, m, zp, use_b ? 8 : 1023);
      do_run(use_b, k, m, 0);
      if (!exp_to) begin
        if (use_b) exp_de_b = {cfg_rd[0], cfg_rd[1], cfg_rd[2], cfg_rd[3]};
        else exp_de_a = {cfg_rd[0], cfg_rd[1], cfg_rd[2], cfg_rd[3]};
      end
      want_de = use_b ? exp_de_b : exp_de_a;
      d = first_diff();
      tests++;
      if (d != -1) begin
        fails++; $display("FAIL rand_seq it %0d first diff %0d got %0d xfers want %0d", it, d,
                          obs_q.size(), exp_q.size());
      end
      tests++;
      if (obs_lat != exp_q.size() + exp_stall || obs_perr != 0) begin
        fails++; $display("FAIL rand_timing it %0d lat %0d proto_err %0d want %0d 0", it,
                          obs_lat, obs_perr, exp_q.size() + exp_stall);
      end
      tests++;
      if (obs_done != (exp_to ? 0 : 1) || obs_to != (exp_to ? 1 : 0) || m_msg_de !== want_de) begin
        fails++; $display("FAIL rand_result it %0d done %0d timeout %0d msg_de %h want %0d %0d %h",
                          it, obs_done, obs_to, m_msg_de, !exp_to, exp_to, want_de);
      end
    end
  endtask

  initial begin
    for (int j = 0; j < 4; j++) cfg_rd[j] = '0;
    test_reset();
    test_nominal();
    test_waitstate();
    test_slow_done();
    test_timeout();
    test_reset_mid_poll();
    test_start_while_busy();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_avalon_master.md
AES_AVALON_MASTER -- requirements
Module: aes_avalon_master

Interface
REQ-001 SHALL have parameter POLL_MAX, default 1023, meaning the maximum number of done-register reads before abort.
REQ-002 SHALL have port CLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have port RESET_N, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port START, input, 1 bit: command request, sampled only in IDLE.
REQ-005 SHALL have port KEY, input, 128 bits: AES key, captured on accepted START.
REQ-006 SHALL have port MSG_EN, input, 128 bits: encrypted message, captured on accepted START.
REQ-007 SHALL have port BUSY, output, 1 bit: high in every state except IDLE.
REQ-008 SHALL have port DONE, output, 1 bit: one-cycle pulse on successful completion.
REQ-009 SHALL have port TIMEOUT, output, 1 bit: one-cycle pulse on poll abort.
REQ-010 SHALL have port MSG_DE, output, 128 bits: decrypted message, held until next update.
REQ-011 SHALL have Avalon-MM master ports: AVL_READ, AVL_WRITE, AVL_CS (out, 1 bit each); AVL_BYTE_EN (out, 4); AVL_ADDR (out, 4); AVL_WRITEDATA (out, 32); AVL_READDATA (in, 32); AVL_WAITREQUEST (in, 1).

Function
REQ-012 SHALL target the slave map: 0-3 key, 4-7 encrypted message, 8-11 decrypted message, 14 start, 15 done.
REQ-013 SHALL map word k (k=0..3) as: addr k <- KEY[127-32k -: 32]; addr 4+k <- MSG_EN[127-32k -: 32]; MSG_DE[127-32k -: 32] <- read of addr 8+k.
REQ-014 SHALL implement states IDLE, WR_KEY, WR_MSG, WR_GO, POLL, RD_DE, WR_CLR, FIN, with a 2-bit word counter used in WR_KEY, WR_MSG and RD_DE.
REQ-015 SHALL, in IDLE with START=1, capture KEY/MSG_EN, clear the word counter and enter WR_KEY on the next edge; START in any other state SHALL be ignored.
REQ-016 SHALL complete a transfer only on a cycle with AVL_WAITREQUEST=0; while waitrequest=1, AVL_ADDR, AVL_WRITEDATA, AVL_READ, AVL_WRITE, AVL_CS and AVL_BYTE_EN SHALL be held stable.
REQ-017 SHALL drive AVL_CS=1 and AVL_BYTE_EN=4'hF on every transfer; with no transfer, all strobes SHALL be 0 and AVL_ADDR/AVL_WRITEDATA SHALL be 0.
REQ-018 SHALL never assert AVL_READ and AVL_WRITE in the same cycle.
REQ-019 SHALL issue back-to-back transfers with no idle cycle between them.
REQ-020 SHALL sequence as follows: WR_KEY writes words 0..3, then WR_MSG writes 4..7, then WR_GO writes 32'h1 to addr 14, then POLL.
REQ-021 SHALL treat reads as zero-latency: AVL_READDATA is sampled in the cycle where AVL_READ=1 and waitrequest=0.
REQ-022 SHALL, in POLL, read addr 15; bit 0 = 1 SHALL enter RD_DE; otherwise the 10-bit poll counter SHALL increment and the read SHALL be reissued on the next cycle.
REQ-023 SHALL, when the poll counter reaches POLL_MAX with done still 0, skip RD_DE and enter WR_CLR with an abort flag set.
REQ-024 SHALL, in RD_DE, read addr 8..11, updating MSG_DE one word per completed read.
REQ-025 SHALL, in WR_CLR, write 32'h0 to addr 14, then enter FIN.
REQ-026 SHALL, in FIN, pulse DONE (no abort) or TIMEOUT (abort) for exactly one cycle, then return to IDLE.
REQ-027 SHALL total 15 transfers for a run with done observed on the first poll and no waitstates, giving DONE 16 cycles after the START-accept edge.
REQ-028 SHALL leave MSG_DE unchanged on timeout.

Reset
REQ-029 SHALL, on RESET_N=0 at any time including mid-transfer, immediately force IDLE, BUSY=0, DONE=0, TIMEOUT=0, MSG_DE=0, all Avalon outputs 0, and counters and abort flag to 0.
REQ-030 SHALL, after RESET_N deasserts, require a new START; no partial sequence SHALL resume.

Verification
REQ-031 SHALL cover this nominal case: KEY=128'h000102030405060708090a0b0c0d0e0f, done on first poll, no waitstates -> addr0 written with 32'h00010203, addr3 with 32'h0c0d0e0f, addr14 with 1 then 0; read data 8..11 = 11111111,22222222,33333333,44444444 gives MSG_DE=128'h11111111222222223333333344444444 and DONE pulse per REQ-027.
REQ-032 SHALL cover waitstates: waitrequest=1 for 3 cycles on the addr5 write -> address and data stable for 4 cycles and the sequence otherwise unchanged.
REQ-033 SHALL cover slow done: done=0 for 20 polls then 1 -> exactly 21 addr-15 reads, then RD_DE and DONE.
REQ-034 SHALL cover timeout: POLL_MAX=8 and done never set -> 8 polls, then the addr14 clear write, then TIMEOUT pulse, DONE=0, and MSG_DE unchanged.
REQ-035 SHALL cover reset mid-POLL: RESET_N low for 1 cycle -> all outputs 0 at once, IDLE, and a subsequent START runs the full sequence from addr0.
REQ-036 SHALL cover START held high or pulsed while BUSY -> no effect; the single run completes and a new run begins only when START=1 in IDLE.
